// File: rtl/mac_err_monitor.sv
// mac_err_monitor: windowed error statistics for an approximate MAC.
// Each accepted sample is an (approx, exact) result pair. Stage 1 registers
// the signed difference and its magnitude. Stage 2 folds them into saturating
// sums, a running maximum and a nonzero-error count. When the WIN-th sample
// has drained through stage 2, a one-cycle done pulse is raised, and
// res_valid is held until the next start.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | after reset, no window opened yet; in_valid ignored
//   S_RUN   | window open, accepting samples until the WIN-th accept
//   S_DRAIN | last sample sits in stage 1, folded into stats this cycle
//   S_DONE  | statistics final (res_valid=1); waits for next start
module mac_err_monitor #(
    parameter int DATA_W = 16,
    parameter int WIN    = 256,
    parameter int SUM_W  = 32,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] approx,
    input  logic [DATA_W-1:0] exact,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    output logic [SUM_W-1:0]  sum_abs,
    output logic [SUM_W-1:0]  bias_sum,
    output logic [DATA_W-1:0] max_err,
    output logic [CNT_W-1:0]  nz_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                     accept;
    logic                     last_accept;
    logic [CNT_W-1:0]         sample_cnt;

    logic signed [DATA_W:0]   diff_c;
    logic [DATA_W-1:0]        abs_c;

    logic                     s1_valid;
    logic [DATA_W-1:0]        s1_abs;
    logic [DATA_W:0]          s1_diff;

    logic [SUM_W:0]           sum_ext;
    logic [SUM_W-1:0]         sum_nxt;
    logic [SUM_W:0]           bias_ext;
    logic [SUM_W-1:0]         bias_nxt;
    logic [DATA_W-1:0]        max_nxt;
    logic [CNT_W-1:0]         nz_nxt;

    // A sample in the start cycle is dropped: start takes priority over data.
    assign accept      = in_valid && (state == S_RUN) && !start;
    assign last_accept = accept && (sample_cnt == CNT_W'(WIN - 1));
    assign busy        = (state == S_RUN) || (state == S_DRAIN);

    // State register.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start re-opens a window from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   if (last_accept) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Difference is one bit wider than the operands, so its magnitude
    // always fits back into DATA_W bits.
    always_comb begin
        diff_c = $signed({1'b0, approx}) - $signed({1'b0, exact});
        abs_c  = diff_c[DATA_W] ? DATA_W'(-diff_c) : DATA_W'(diff_c);
    end

    // Stage 1: capture the difference of an accepted sample and count it.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_valid   <= 1'b0;
            s1_abs     <= '0;
            s1_diff    <= '0;
            sample_cnt <= '0;
        end else if (start) begin
            s1_valid   <= 1'b0;
            s1_abs     <= '0;
            s1_diff    <= '0;
            sample_cnt <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_abs     <= abs_c;
                s1_diff    <= diff_c;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2 arithmetic: sums carry one guard bit to detect overflow, and
    // clamp instead of wrapping.
    always_comb begin
        sum_ext = {1'b0, sum_abs} + {{(SUM_W + 1 - DATA_W){1'b0}}, s1_abs};
        sum_nxt = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

        bias_ext = {bias_sum[SUM_W-1], bias_sum}
                 + {{(SUM_W - DATA_W){s1_diff[DATA_W]}}, s1_diff};
        if (bias_ext[SUM_W] != bias_ext[SUM_W-1]) begin
            bias_nxt = bias_ext[SUM_W] ? {1'b1, {(SUM_W - 1){1'b0}}}
                                       : {1'b0, {(SUM_W - 1){1'b1}}};
        end else begin
            bias_nxt = bias_ext[SUM_W-1:0];
        end

        max_nxt = (s1_abs > max_err) ? s1_abs : max_err;
        nz_nxt  = nz_cnt + CNT_W'(s1_abs != '0);
    end

    // Stage 2 registers: live statistics, cleared by start.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sum_abs  <= '0;
            bias_sum <= '0;
            max_err  <= '0;
            nz_cnt   <= '0;
        end else if (start) begin
            sum_abs  <= '0;
            bias_sum <= '0;
            max_err  <= '0;
            nz_cnt   <= '0;
        end else if (s1_valid) begin
            sum_abs  <= sum_nxt;
            bias_sum <= bias_nxt;
            max_err  <= max_nxt;
            nz_cnt   <= nz_nxt;
        end
    end

    // Completion flags: registered on DRAIN so they rise with DONE entry,
    // the same edge that commits the last sample's statistics.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            done      <= 1'b0;
            res_valid <= 1'b0;
        end else if (start) begin
            done      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            done <= (state == S_DRAIN);
            if (state == S_DRAIN) begin
                res_valid <= 1'b1;
            end
        end
    end

endmodule
